// File: rtl/cordic_engine.sv
// Pipelined CORDIC (rotation/vectoring) with quadrant pre-rotation and output saturation.
// Define CORDIC_GAIN_COMP_EN to scale x/y by 1/K in the output stage.
module cordic_engine #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ITERATION_CNT = 14,
    parameter int unsigned TAG_WIDTH     = 8
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         s_mode,
    input  logic [TAG_WIDTH-1:0]         s_tag,
    input  logic signed [DATA_WIDTH-1:0] s_x,
    input  logic signed [DATA_WIDTH-1:0] s_y,
    input  logic [31:0]                  s_z,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [TAG_WIDTH-1:0]         m_tag,
    output logic signed [DATA_WIDTH-1:0] m_x,
    output logic signed [DATA_WIDTH-1:0] m_y,
    output logic [31:0]                  m_z
);

    localparam int unsigned IW = DATA_WIDTH + 2;
    localparam int unsigned N  = ITERATION_CNT;
    localparam logic signed [IW-1:0] SMAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [IW-1:0] SMIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    function automatic logic [31:0] atan_lut(input int unsigned i);
        case (i)
            0:  atan_lut = 32'h2000_0000;
            1:  atan_lut = 32'h12E4_051E;
            2:  atan_lut = 32'h09FB_385B;
            3:  atan_lut = 32'h0511_11D4;
            4:  atan_lut = 32'h028B_0D43;
            5:  atan_lut = 32'h0145_D7E1;
            6:  atan_lut = 32'h00A2_F61E;
            7:  atan_lut = 32'h0051_7C55;
            8:  atan_lut = 32'h0028_BE53;
            9:  atan_lut = 32'h0014_5F2F;
            10: atan_lut = 32'h000A_2F98;
            11: atan_lut = 32'h0005_17CC;
            12: atan_lut = 32'h0002_8BE6;
            13: atan_lut = 32'h0001_45F3;
            14: atan_lut = 32'h0000_A2FA;
            15: atan_lut = 32'h0000_517D;
            16: atan_lut = 32'h0000_28BE;
            17: atan_lut = 32'h0000_145F;
            18: atan_lut = 32'h0000_0A30;
            19: atan_lut = 32'h0000_0518;
            20: atan_lut = 32'h0000_028C;
            21: atan_lut = 32'h0000_0146;
            22: atan_lut = 32'h0000_00A3;
            23: atan_lut = 32'h0000_0051;
            24: atan_lut = 32'h0000_0029;
            25: atan_lut = 32'h0000_0014;
            26: atan_lut = 32'h0000_000A;
            27: atan_lut = 32'h0000_0005;
            28: atan_lut = 32'h0000_0003;
            29: atan_lut = 32'h0000_0001;
            default: atan_lut = '0;
        endcase
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SMAX)      sat = SMAX[DATA_WIDTH-1:0];
        else if (v < SMIN) sat = SMIN[DATA_WIDTH-1:0];
        else               sat = v[DATA_WIDTH-1:0];
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned KC_INT = $rtoi(0.607253 * (2.0 ** (DATA_WIDTH + 1)) + 0.5);
    localparam logic [IW-1:0] KC = KC_INT[IW-1:0];
    localparam int unsigned PW = 2 * IW + 1;
    localparam logic signed [PW-1:0] HALF = {{(PW-DATA_WIDTH-1){1'b0}}, 1'b1, {DATA_WIDTH{1'b0}}};

    function automatic logic signed [IW-1:0] gain(input logic signed [IW-1:0] v);
        logic signed [PW-1:0] p;
        p = PW'(v) * PW'($signed({1'b0, KC}));
        p = (p + HALF) >>> (DATA_WIDTH + 1);
        gain = IW'(p);
    endfunction
`endif

    // Index 0 is the pre-rotation stage, index i+1 the output of micro-rotation i.
    logic                  v_s   [0:N];
    logic                  md_s  [0:N];
    logic [TAG_WIDTH-1:0]  tag_s [0:N];
    logic signed [IW-1:0]  x_s   [0:N];
    logic signed [IW-1:0]  y_s   [0:N];
    logic [31:0]           z_s   [0:N];

    logic signed [IW-1:0]  x_n   [0:N];
    logic signed [IW-1:0]  y_n   [0:N];
    logic [31:0]           z_n   [0:N];
    logic signed [IW-1:0]  sx, sy;
    logic                  flip;
    logic signed [DATA_WIDTH-1:0] ox, oy;
    logic                  ce;

    assign ce      = m_ready | ~m_valid;
    assign s_ready = ce & ~areset;

    always_comb begin
        sx   = IW'(s_x);
        sy   = IW'(s_y);
        // Fold the left half-plane onto the right so the micro-rotations only cover +-90 deg.
        flip = s_mode ? s_x[DATA_WIDTH-1] : (s_z[31] ^ s_z[30]);
        x_n[0] = flip ? -sx : sx;
        y_n[0] = flip ? -sy : sy;
        z_n[0] = flip ? s_z + 32'h8000_0000 : s_z;
        for (int unsigned i = 0; i < N; i++) begin
            if (md_s[i] ? y_s[i][IW-1] : ~z_s[i][31]) begin
                x_n[i+1] = x_s[i] - (y_s[i] >>> i);
                y_n[i+1] = y_s[i] + (x_s[i] >>> i);
                z_n[i+1] = z_s[i] - atan_lut(i);
            end else begin
                x_n[i+1] = x_s[i] + (y_s[i] >>> i);
                y_n[i+1] = y_s[i] - (x_s[i] >>> i);
                z_n[i+1] = z_s[i] + atan_lut(i);
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        ox = sat(gain(x_s[N]));
        oy = sat(gain(y_s[N]));
`else
        ox = sat(x_s[N]);
        oy = sat(y_s[N]);
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i <= N; i++) begin
                v_s[i]   <= 1'b0;
                md_s[i]  <= 1'b0;
                tag_s[i] <= '0;
                x_s[i]   <= '0;
                y_s[i]   <= '0;
                z_s[i]   <= '0;
            end
            m_valid <= 1'b0;
            m_tag   <= '0;
            m_x     <= '0;
            m_y     <= '0;
            m_z     <= '0;
        end else if (ce) begin
            v_s[0]   <= s_valid;
            md_s[0]  <= s_mode;
            tag_s[0] <= s_tag;
            for (int unsigned i = 1; i <= N; i++) begin
                v_s[i]   <= v_s[i-1];
                md_s[i]  <= md_s[i-1];
                tag_s[i] <= tag_s[i-1];
            end
            for (int unsigned i = 0; i <= N; i++) begin
                x_s[i] <= x_n[i];
                y_s[i] <= y_n[i];
                z_s[i] <= z_n[i];
            end
            m_valid <= v_s[N];
            m_tag   <= tag_s[N];
            m_x     <= ox;
            m_y     <= oy;
            m_z     <= z_s[N];
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed self-checking bench for cordic_engine; expectations follow CORDIC_GAIN_COMP_EN.
module tb_cordic_engine;

    localparam int DW  = 16;
    localparam int N   = 14;
    localparam int TW  = 8;
    localparam int LAT = N + 2;
    localparam int ZTOL = 1 << 19;

`ifdef CORDIC_GAIN_COMP_EN
    localparam real G        = 1.0;
    localparam int  ROT45    = 11314;
    localparam int  VMAG     = 5000;
    localparam int  ROT135   = -7071;
    localparam int  TOL      = 4;
    localparam int  VTOL     = 4;
`else
    localparam real G        = 1.6467602;
    localparam int  ROT45    = 18631;
    localparam int  VMAG     = 8234;
    localparam int  ROT135   = -11644;
    localparam int  TOL      = 8;
    localparam int  VTOL     = 6;
`endif

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic                 s_mode = 1'b0;
    logic [TW-1:0]        s_tag = '0;
    logic signed [DW-1:0] s_x = '0;
    logic signed [DW-1:0] s_y = '0;
    logic [31:0]          s_z = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic [TW-1:0]        m_tag;
    logic signed [DW-1:0] m_x;
    logic signed [DW-1:0] m_y;
    logic [31:0]          m_z;

    int n_pass = 0;
    int n_total = 0;

    cordic_engine #(.DATA_WIDTH(DW), .ITERATION_CNT(N), .TAG_WIDTH(TW)) dut (
        .aclk(aclk), .areset(areset),
        .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode), .s_tag(s_tag),
        .s_x(s_x), .s_y(s_y), .s_z(s_z),
        .m_valid(m_valid), .m_ready(m_ready), .m_tag(m_tag),
        .m_x(m_x), .m_y(m_y), .m_z(m_z)
    );

    always #5 aclk = ~aclk;

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int zdist(input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        d = a - e;
        return absi($signed(d));
    endfunction

    // Offers one sample to an empty pipeline and waits (bounded) for its result.
    task automatic run_one(input logic md, input logic [TW-1:0] tg, input int x, input int y,
                           input logic [31:0] z, output int lat);
        @(negedge aclk);
        s_valid = 1'b1; s_mode = md; s_tag = tg;
        s_x = 16'(x); s_y = 16'(y); s_z = z; m_ready = 1'b1;
        @(posedge aclk);
        lat = 1;
        @(negedge aclk);
        s_valid = 1'b0;
        while (!m_valid && lat < 200) begin
            @(posedge aclk); lat++;
            @(negedge aclk);
        end
        if (!m_valid) lat = -1;
    endtask

    task automatic test_reset();
        areset = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
        n_total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_valid); else n_pass++;
        n_total++; if (m_x !== 16'sd0) $display("FAIL rst_m_x: got %0d want 0", m_x); else n_pass++;
        n_total++; if (m_y !== 16'sd0) $display("FAIL rst_m_y: got %0d want 0", m_y); else n_pass++;
        n_total++; if (m_z !== 32'h0) $display("FAIL rst_m_z: got %h want 0", m_z); else n_pass++;
        n_total++; if (m_tag !== 8'h00) $display("FAIL rst_m_tag: got %h want 0", m_tag); else n_pass++;
        areset = 1'b0;
        #1;
        n_total++; if (s_ready !== 1'b1) $display("FAIL post_rst_s_ready: got %b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_rotation();
        int lat;
        run_one(1'b0, 8'h11, 16000, 0, 32'h2000_0000, lat);
        n_total++; if (lat !== LAT) $display("FAIL rot45_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_total++; if (m_tag !== 8'h11) $display("FAIL rot45_tag: got %h want 11", m_tag); else n_pass++;
        n_total++; if (absi(int'(m_x) - ROT45) > TOL) $display("FAIL rot45_x: got %0d want %0d", m_x, ROT45); else n_pass++;
        n_total++; if (absi(int'(m_y) - ROT45) > TOL) $display("FAIL rot45_y: got %0d want %0d", m_y, ROT45); else n_pass++;
        n_total++; if (zdist(m_z, 32'h0) > ZTOL) $display("FAIL rot45_z: got %h want ~0", m_z); else n_pass++;
    endtask

    task automatic test_vectoring();
        int lat;
        run_one(1'b1, 8'h22, 3000, 4000, 32'h0, lat);
        n_total++; if (lat !== LAT) $display("FAIL vec_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_total++; if (absi(int'(m_x) - VMAG) > VTOL) $display("FAIL vec_x: got %0d want %0d", m_x, VMAG); else n_pass++;
        n_total++; if (absi(int'(m_y)) > 4) $display("FAIL vec_y: got %0d want ~0", m_y); else n_pass++;
        n_total++; if (zdist(m_z, 32'h25C8_0000) > ZTOL) $display("FAIL vec_z: got %h want ~25c80000", m_z); else n_pass++;
    endtask

    task automatic test_full_circle();
        int lat;
        run_one(1'b0, 8'h33, 10000, 0, 32'hA000_0000, lat);
        n_total++; if (absi(int'(m_x) - ROT135) > TOL) $display("FAIL rot135_x: got %0d want %0d", m_x, ROT135); else n_pass++;
        n_total++; if (absi(int'(m_y) - ROT135) > TOL) $display("FAIL rot135_y: got %0d want %0d", m_y, ROT135); else n_pass++;
        run_one(1'b1, 8'h44, -5000, 0, 32'h0, lat);
        n_total++; if (zdist(m_z, 32'h8000_0000) > ZTOL) $display("FAIL vec180_z: got %h want ~80000000", m_z); else n_pass++;
        n_total++; if (absi(int'(m_x) - VMAG) > VTOL) $display("FAIL vec180_x: got %0d want %0d", m_x, VMAG); else n_pass++;
    endtask

    task automatic test_saturation();
        int lat;
        run_one(1'b1, 8'h55, 32767, 32767, 32'h0, lat);
        n_total++; if (m_x !== 16'sd32767) $display("FAIL sat_x: got %0d want 32767", m_x); else n_pass++;
        n_total++; if (absi(int'(m_y)) > 16) $display("FAIL sat_y: got %0d want ~0", m_y); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        @(negedge aclk);
        m_ready = 1'b1;
        s_valid = 1'b1; s_mode = 1'b1; s_tag = 8'h01; s_x = 16'sd3000; s_y = 16'sd4000; s_z = 32'h0;
        @(negedge aclk);
        s_mode = 1'b0; s_tag = 8'h02; s_x = 16'sd16000; s_y = 16'sd0; s_z = 32'h2000_0000;
        @(negedge aclk);
        s_valid = 1'b0;
        while (!m_valid && cyc < 100) begin @(negedge aclk); cyc++; end
        n_total++; if (m_tag !== 8'h01 || m_valid !== 1'b1) $display("FAIL b2b_first_tag: got %h want 01", m_tag); else n_pass++;
        n_total++; if (absi(int'(m_x) - VMAG) > VTOL) $display("FAIL b2b_vec_x: got %0d want %0d", m_x, VMAG); else n_pass++;
        @(negedge aclk);
        n_total++; if (m_tag !== 8'h02 || m_valid !== 1'b1) $display("FAIL b2b_second_tag: got %h want 02", m_tag); else n_pass++;
        n_total++; if (absi(int'(m_y) - ROT45) > TOL) $display("FAIL b2b_rot_y: got %0d want %0d", m_y, ROT45); else n_pass++;
    endtask

    task automatic test_backpressure();
        int sent = 0, rcv = 0, cyc = 0, want;
        logic prev_stall = 1'b0;
        logic [TW-1:0] ptag = '0;
        logic signed [DW-1:0] px = '0, py = '0;
        while (rcv < 40 && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            m_ready = ($urandom_range(0, 1) == 1);
            s_valid = (sent < 40);
            s_mode = 1'b0; s_tag = 8'(sent); s_x = 16'(1000 + 100 * sent); s_y = '0; s_z = 32'h0;
            #1;
            if (prev_stall) begin
                n_total++;
                if (m_valid !== 1'b1 || m_tag !== ptag || m_x !== px || m_y !== py)
                    $display("FAIL bp_hold: got v=%b tag=%0d x=%0d y=%0d want v=1 tag=%0d x=%0d y=%0d",
                             m_valid, m_tag, m_x, m_y, ptag, px, py);
                else n_pass++;
            end
            if (m_valid && !m_ready) begin
                n_total++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready: got %b want 0", s_ready); else n_pass++;
            end
            if (m_valid && m_ready) begin
                want = $rtoi((1000.0 + 100.0 * rcv) * G + 0.5);
                n_total++; if (m_tag !== 8'(rcv)) $display("FAIL bp_order: got tag %0d want %0d", m_tag, rcv); else n_pass++;
                n_total++; if (absi(int'(m_x) - want) > TOL) $display("FAIL bp_x: got %0d want %0d", m_x, want); else n_pass++;
                rcv++;
            end
            prev_stall = m_valid && !m_ready;
            ptag = m_tag; px = m_x; py = m_y;
            if (s_valid && s_ready) sent++;
        end
        n_total++; if (rcv !== 40) $display("FAIL bp_count: got %0d want 40", rcv); else n_pass++;
        @(negedge aclk);
        s_valid = 1'b0; m_ready = 1'b1;
        repeat (LAT + 2) @(negedge aclk);
        n_total++; if (m_valid !== 1'b0) $display("FAIL bp_extra: got m_valid %b want 0", m_valid); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int lat = 0, first = -1, pulses = 0;
        logic [TW-1:0] ftag = '0;
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            s_valid = 1'b1; s_mode = k[0]; s_tag = 8'(100 + k);
            s_x = 16'sd1234; s_y = 16'sd567; s_z = 32'h1000_0000;
        end
        @(negedge aclk);
        areset = 1'b1; s_tag = 8'hEE;
        #1;
        n_total++; if (s_ready !== 1'b0) $display("FAIL midrst_s_ready: got %b want 0", s_ready); else n_pass++;
        @(negedge aclk);
        areset = 1'b0;
        n_total++; if (m_valid !== 1'b0) $display("FAIL midrst_m_valid: got %b want 0", m_valid); else n_pass++;
        s_valid = 1'b1; s_mode = 1'b0; s_tag = 8'hAB; s_x = 16'sd2000; s_y = '0; s_z = 32'h0;
        @(posedge aclk);
        lat = 1;
        @(negedge aclk);
        s_valid = 1'b0;
        repeat (40) begin
            if (m_valid) begin
                pulses++;
                if (first < 0) begin first = lat; ftag = m_tag; end
            end
            @(posedge aclk); lat++;
            @(negedge aclk);
        end
        n_total++; if (first !== LAT) $display("FAIL midrst_latency: got %0d want %0d", first, LAT); else n_pass++;
        n_total++; if (ftag !== 8'hAB) $display("FAIL midrst_tag: got %h want ab", ftag); else n_pass++;
        n_total++; if (pulses !== 1) $display("FAIL midrst_pulses: got %0d want 1", pulses); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_vectoring();
        test_full_circle();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_engine.md
# cordic_engine

- Fully pipelined CORDIC core, parametrised in data width and iteration count.
- Selects rotation or vectoring mode per sample, and passes a sideband tag alongside each sample.
- A valid/ready handshake with backpressure makes it a drop-in datapath stage between streaming blocks.
- Adds full-circle quadrant pre-rotation and output saturation ahead of NCO/mixer and magnitude/phase consumers.

## Interface
- DATA_WIDTH, 16: width of signed x/y samples (8..30).
- ITERATION_CNT, 14: number of micro-rotation stages (1..30).
- TAG_WIDTH, 8: width of opaque sideband tag (≥1).

Reset is synchronous and active-high; one clock.

- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  synchronous active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  engine accepts input this cycle.
- s_mode  in  1  0 = rotation, 1 = vectoring.
- s_tag  in  TAG_WIDTH  sideband, returned unchanged with result.
- s_x, s_y  in  DATA_WIDTH  signed two's-complement inputs.
- s_z  in  32  angle; binary full-turn format, 2^32 = 360°, signed view ±180°.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_tag  out  TAG_WIDTH  tag of this result.
- m_x, m_y  out  DATA_WIDTH  signed results, saturated.
- m_z  out  32  residual/accumulated angle.

## Operation
- Internal x/y width is DATA_WIDTH+2 (sign-extended inputs); z is 32 bits, wrapping modulo 2^32.
- Stage P is the pre-rotation stage, registered:
  - Rotation mode, z[31:30] ∈ {01,10}: x←−x, y←−y, z←z+0x8000_0000.
  - Vectoring mode, x<0: x←−x, y←−y, z←z+0x8000_0000.
  - Otherwise values pass unchanged.
- Stage i (0..ITERATION_CNT−1) is registered:
  - d=+1 if (rotation and z≥0) or (vectoring and y<0), else d=−1.
  - x←x−d·(y>>>i), y←y+d·(x>>>i), z←z−d·A[i].
  - A[i]=round(atan(2^−i)·2^32/2π), so A[0]=0x2000_0000.
  - Shifts are arithmetic; the table is a localparam function of i.
- Stage O is the output stage, registered:
  - Optional gain compensation (see Configuration).
  - x/y are then saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; z passes through.
- mode and tag travel with each sample in every stage.
- Each stage has a valid bit; pipeline advance enable is ce = m_ready | ~m_valid.
  - When ce=1, all stages shift by one.
  - When ce=0, all stages hold, including data, valid, tag and mode.
- s_ready = ce, combinational; a sample is accepted when s_valid & s_ready.
- Bubbles propagate as valid=0.
- Reset:
  - areset=1 clears every valid bit and every data/tag/mode register to 0 at the next edge.
  - In-flight samples are discarded.
  - Reset has priority over ce.
  - s_ready is held 0 while areset=1.

## Timing
- Latency is ITERATION_CNT+2 cycles from accept edge to m_valid (default 16), independent of macro or mode.
- Throughput is 1 sample/cycle while m_ready=1.
- Reset values: m_valid=0, m_x=0, m_y=0, m_z=0, m_tag=0; s_ready=0 during reset, 1 in the first cycle after.
- Backpressure:
  - With m_valid=1 and m_ready=0, outputs are stable and s_ready=0.
  - An input offered in that cycle is not accepted.
- Simultaneous accept and output pop in one cycle are permitted; no sample is lost or duplicated.
- Mixed-mode samples back-to-back are processed independently.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - Stage O multiplies x and y by Kc = round(0.607253·2^(DATA_WIDTH+1)).
  - The constant is unsigned; the product is arithmetically shifted right by DATA_WIDTH+1, round-half-up.
  - Results are true rotation/magnitude.
- CORDIC_GAIN_COMP_EN undefined:
  - No multiplier; Stage O only saturates.
  - x/y carry CORDIC gain ≈1.6468.
  - Latency is unchanged.

## Test plan
- Rotation, gain comp on: x=16000, y=0, z=0x2000_0000 (45°) → m_x≈m_y≈11314 ±4, m_z≈0 ±2^19.
- Vectoring, gain comp off: x=3000, y=4000, z=0 → m_x≈8234 ±6, m_y≈0 ±4, m_z≈0x25C8_0000 ±2^19.
- Full-circle rotation: x=10000, y=0, z=0xA000_0000 (−135°, comp on) → m_x≈m_y≈−7071 ±4; vectoring x=−5000, y=0 → m_z≈0x8000_0000 ±2^19, m_x≈5000.
- Saturation, comp off: x=y=32767, vectoring → m_x=32767 exactly (clamped), m_y≈0.
- Backpressure: stream 40 samples with tags 0..39 while m_ready toggles pseudo-randomly → all 40 out in order, tags intact, outputs stable while stalled, s_ready=0 whenever m_valid & ~m_ready.
- Reset mid-stream: assert areset for 1 cycle with 10 samples in flight → m_valid=0 the next cycle and no stale sample emerges; a sample accepted after reset appears exactly ITERATION_CNT+2 cycles later.
